// File: rtl/nbit_sort_ctrl.sv
// Eight-entry signed bubble sorter: load entries while idle, start sorts ascending in place.
// One compare per cycle; a sort finishes early after a pass with no swaps, or after at most 7 passes.
module nbit_sort_ctrl #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [n-1:0] load_data,
  input  logic         start,
  input  logic [2:0]   rd_idx,
  output logic [n-1:0] rd_data,
  output logic         busy,
  output logic         done,
  output logic [5:0]   swap_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SORT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [n-1:0]        entry [0:7];
  logic [2:0]          wr_ptr;
  logic [2:0]          i;
  logic [2:0]          i_nxt;
  logic [2:0]          pass_cnt;
  logic                pass_swap;
  logic signed [n-1:0] a;
  logic signed [n-1:0] b;
  logic                lt;

  assign i_nxt = i + 3'd1;
  assign a     = entry[i_nxt];
  assign b     = entry[i];
  // Both operands are declared signed, so this is a true two's-complement compare.
  assign lt    = (a < b);

  assign rd_data = entry[rd_idx];
  assign busy    = (state == SORT);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= 3'd0;
      swap_cnt  <= 6'd0;
      i         <= 3'd0;
      pass_cnt  <= 3'd0;
      pass_swap <= 1'b0;
      for (int k = 0; k < 8; k++) entry[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            entry[wr_ptr] <= load_data;
            wr_ptr        <= wr_ptr + 3'd1;
          end else if (start) begin
            swap_cnt  <= 6'd0;
            i         <= 3'd0;
            pass_cnt  <= 3'd0;
            pass_swap <= 1'b0;
            state     <= SORT;
          end
        end
        SORT: begin
          if (lt) begin
            entry[i]     <= a;
            entry[i_nxt] <= b;
            pass_swap    <= 1'b1;
            if (swap_cnt != 6'h3f) swap_cnt <= swap_cnt + 6'd1;
          end
          if (i == 3'd6) begin
            // The swap at i=6 counts toward this pass, so fold lt in.
            if (!(pass_swap || lt) || (pass_cnt == 3'd6)) begin
              state <= DONE;
            end else begin
              i         <= 3'd0;
              pass_cnt  <= pass_cnt + 3'd1;
              pass_swap <= 1'b0;
            end
          end else begin
            i <= i_nxt;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_sort_ctrl.sv
// Directed bench for nbit_sort_ctrl: scoreboard of expected sorted contents checked on done.
module tb_nbit_sort_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] load_data;
  logic       start;
  logic [2:0] rd_idx;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [5:0] swap_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] vals [8];
  logic [7:0] exp_q [$];
  int         exp_swaps;

  always #5 clk = ~clk;

  nbit_sort_ctrl #(.n(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .start     (start),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .swap_cnt  (swap_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    @(negedge clk);
    load      = 1'b1;
    load_data = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Reference: independent insertion sort plus inversion count for the expected swap total.
  task automatic push_expected();
    logic signed [7:0] t [8];
    logic signed [7:0] key;
    int j;
    for (int k = 0; k < 8; k++) t[k] = vals[k];
    for (int k = 1; k < 8; k++) begin
      key = t[k];
      j = k - 1;
      while (j >= 0 && t[j] > key) begin
        t[j+1] = t[j];
        j--;
      end
      t[j+1] = key;
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(t[k]);
    exp_swaps = 0;
    for (int p = 0; p < 8; p++)
      for (int q = p + 1; q < 8; q++)
        if ($signed(vals[p]) > $signed(vals[q])) exp_swaps++;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 8; k++) begin
      rd_idx = k[2:0];
      #1;
      chk(tag, {24'd0, rd_data}, 32'd0);
    end
  endtask

  task automatic run_sort(input string tag, input int exp_busy, input bit disturb);
    int  busy_n;
    bit  seen;
    logic [7:0] e;
    for (int k = 0; k < 8; k++) do_load(vals[k]);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
    busy_n = 0;
    seen   = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_n++;
        if (disturb) begin
          load = 1'b1; start = 1'b1; load_data = 8'h55;
        end
        @(negedge clk);
      end
    end
    load  = 1'b0;
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    if (exp_busy >= 0) chk({tag, "_busy_cycles"}, busy_n, exp_busy);
    chk({tag, "_swap_cnt"}, {26'd0, swap_cnt}, exp_swaps);
    @(negedge clk);
    chk({tag, "_done_pulse_1cyc"}, {31'd0, done}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      rd_idx = k[2:0];
      #1;
      e = exp_q.pop_front();
      chk({tag, "_rd"}, {24'd0, rd_data}, {24'd0, e});
    end
  endtask

  initial begin
    int done_n;
    reset = 1'b1; load = 1'b0; start = 1'b0; load_data = 8'h00; rd_idx = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_swap", {26'd0, swap_cnt}, 32'd0);
    check_all_zero("rst_rd");

    for (int k = 0; k < 8; k++) vals[k] = 8'(k + 1);
    run_sort("asc", 7, 1'b0);

    for (int k = 0; k < 8; k++) vals[k] = 8'(8 - k);
    run_sort("desc", 49, 1'b1);

    vals[0] = 8'h80; vals[1] = 8'h7f; vals[2] = 8'hff; vals[3] = 8'h00;
    vals[4] = 8'h01; vals[5] = 8'hfe; vals[6] = 8'h05; vals[7] = 8'h80;
    run_sort("mixed", 49, 1'b0);

    for (int k = 0; k < 8; k++) vals[k] = 8'd3;
    run_sort("equal", 7, 1'b0);

    for (int k = 0; k < 8; k++) vals[k] = 8'($urandom_range(0, 255));
    run_sort("rand", -1, 1'b0);

    // load+start together: load wins, no sort begins
    @(negedge clk);
    load = 1'b1; start = 1'b1; load_data = 8'h11;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("ldst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ldst_busy2", {31'd0, busy}, 32'd0);
    rd_idx = 3'd0; #1;
    chk("ldst_stored", {24'd0, rd_data}, 32'h11);
    for (int k = 1; k < 8; k++) do_load(8'(8'h20 + k));
    do_load(8'h99);
    rd_idx = 3'd0; #1;
    chk("wrap_entry0", {24'd0, rd_data}, 32'h99);
    rd_idx = 3'd1; #1;
    chk("wrap_entry1", {24'd0, rd_data}, 32'h21);
    chk("swap_hold", {26'd0, swap_cnt}, exp_swaps);

    // reset in the middle of a sort
    for (int k = 0; k < 8; k++) do_load(8'(8 - k));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_swap", {26'd0, swap_cnt}, 32'd0);
    check_all_zero("mid_rd");
    done_n = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) done_n++;
      @(negedge clk);
    end
    chk("mid_no_done", done_n, 32'd0);

    for (int k = 0; k < 8; k++) vals[k] = 8'(8'hf0 + k);
    run_sort("post_rst", 7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
